booth_radix4_seq_multiplier: RTL

Parametrised sequential radix-4 (modified Booth) multiplier. Successor to the radix-2 booth and shift-accumulate multipliers in the multipliers group: twice the bits retired per cycle, configurable operand width, and per-operation signed/unsigned mode. It keeps the start/done handshake those blocks use, so the existing post-synthesis bench style applies unchanged.

---
 rtl/booth_radix4_seq_multiplier.sv | 86 ++++++++
 1 files changed

// File: rtl/booth_radix4_seq_multiplier.sv
// booth_radix4_seq_multiplier: sequential radix-4 Booth multiplier, start/done handshake, signed/unsigned mode, optional BOOTH_EARLY_TERM_EN early termination
module booth_radix4_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
    output logic               busy
);
    localparam int STEPS = (WIDTH + 2) / 2;
    localparam int E = WIDTH + 2;
    localparam int A = WIDTH + 3;
    localparam int CW = $clog2(STEPS + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state;
    logic [A-1:0] r_m;
    logic [A-1:0] r_acc;
    logic [E-1:0] r_q;
    logic r_qm1;
    logic [CW-1:0] r_cnt;
    logic [2:0] w_dig;
    logic [A-1:0] w_pp;
    logic [A-1:0] w_sum;
    logic signed [A+E:0] w_next;
    logic w_last;
    logic [2*WIDTH-1:0] w_res;
    assign w_dig = {r_q[1:0], r_qm1};
    always_comb
        w_pp = (w_dig == 3'b001 || w_dig == 3'b010) ? r_m :
               (w_dig == 3'b011) ? r_m << 1 :
               (w_dig == 3'b100) ? -(r_m << 1) :
               (w_dig == 3'b101 || w_dig == 3'b110) ? -r_m : '0;
    assign w_sum = r_acc + w_pp;
    assign w_next = $signed({w_sum, r_q, r_qm1}) >>> 2;
`ifdef BOOTH_EARLY_TERM_EN
    logic [E:0] w_mask;
    logic [CW-1:0] w_rem;
    assign w_mask = {(E+1){1'b1}} >> (2 * (r_cnt + 1'b1));
    assign w_rem = CW'(STEPS - 1) - r_cnt;
    assign w_last = r_cnt == CW'(STEPS - 1) || (w_next[E:0] & w_mask) == '0 || (w_next[E:0] | ~w_mask) == '1;
    assign w_res = (2*WIDTH)'($signed(w_next[A+E:1]) >>> (2 * w_rem));
`else
    assign w_last = r_cnt == CW'(STEPS - 1);
    assign w_res = w_next[2*WIDTH:1];
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            result <= '0;
            done <= 1'b0;
            busy <= 1'b0;
            r_m <= '0;
            r_acc <= '0;
            r_q <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
        end else if (r_state != RUN) begin
            if (start) begin
                r_state <= RUN;
                done <= 1'b0;
                busy <= 1'b1;
                r_m <= {{3{signed_mode & M[WIDTH-1]}}, M};
                r_q <= {{2{signed_mode & Q[WIDTH-1]}}, Q};
                r_acc <= '0;
                r_qm1 <= 1'b0;
                r_cnt <= '0;
            end
        end else begin
            r_acc <= w_next[A+E:E+1];
            r_q <= w_next[E:1];
            r_qm1 <= w_next[0];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_state <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
                result <= w_res;
            end
        end
    end
endmodule
